or_req_rr_arbiter: RTL

//  Round-robin arbiter that shares one downstream resource among N requesters.
//  The block ORs all requests into a combinational any_req summary.
//  It issues a registered one-hot grant, held while the owner keeps req high.
//  An optional hold-time limit preempts a long-running owner when others are waiting.

---
 rtl/or_req_rr_arbiter_if.sv | 32 +++
 rtl/or_req_rr_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/or_req_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// Arbiter owns any_req/gnt/gnt_valid/gnt_id/preempt; requesters own req.
interface or_req_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           any_req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           preempt;

    modport master (
        output req,
        input  any_req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output any_req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );
endinterface

// File: rtl/or_req_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner hold and optional
// hold-time preemption. Handshake: requester i owns the resource while gnt[i]=1 and keeps req[i]=1; dropping req[i] releases it at the next edge.
module or_req_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    or_req_rr_arbiter_if.slave    bus,
    output logic                  dbg_state
);
    localparam int IDW         = $clog2(N);
    localparam int HCW         = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_LAST_I);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic           run_q;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic           preempt_d;
    logic           do_grant;
    logic [N-1:0]   cand;
    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic [N-1:0]   others;
    logic           timeout;

    assign bus.any_req = |bus.req;
    assign dbg_state   = state_q;

    assign owner_req = |(bus.req & bus.gnt);
    assign others    = bus.req & ~bus.gnt;
    assign timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // On a preemption the current owner is excluded from the search.
    always_comb begin
        cand = bus.req;
        if (state_q == GRANT && owner_req && timeout) begin
            cand = others;
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = bus.gnt;
        gnt_id_d  = bus.gnt_id;
        preempt_d = 1'b0;
        do_grant  = 1'b0;

        if (run_q) begin
            case (state_q)
                IDLE: begin
                    if (bus.any_req) do_grant = 1'b1;
                end
                GRANT: begin
                    if (!owner_req) begin
                        if (bus.any_req) begin
                            do_grant = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            gnt_d    = '0;
                            gnt_id_d = '0;
                        end
                    end else if (timeout && (|others)) begin
                        do_grant  = 1'b1;
                        preempt_d = 1'b1;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_grant) begin
            state_d         = GRANT;
            gnt_d           = '0;
            gnt_d[win_id]   = 1'b1;
            gnt_id_d        = win_id;
            hold_d          = '0;
            ptr_d           = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // run_q delays the first decision by one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_q        <= '0;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= '0;
            bus.preempt   <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            bus.gnt       <= gnt_d;
            bus.gnt_valid <= |gnt_d;
            bus.gnt_id    <= gnt_id_d;
            bus.preempt   <= preempt_d;
        end
    end
endmodule
